// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and buart-side signals shared by the arbiter and its surroundings.
// master drives requests and buart busy; slave is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_lock;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   grant;
   logic              uart_busy;
   logic              uart_wr;
   logic [7:0]        uart_data;
   logic [15:0]       bytes_sent;

   modport master (
      output req_valid, req_data, req_lock, uart_busy,
      input  req_ready, grant, uart_wr, uart_data, bytes_sent
   );

   modport slave (
      input  req_valid, req_data, req_lock, uart_busy,
      output req_ready, grant, uart_wr, uart_data, bytes_sent
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin per-byte arbiter sharing one buart transmitter between NREQ producers,
// with an optional per-requester lock that keeps ownership across a multi-byte message.
module uart_tx_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic             clk,
   input  logic             reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      STROBE,
      GUARD
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] ready_q, ready_d;
   logic            wr_q, wr_d;
   logic [7:0]      data_q, data_d;
   logic [15:0]     sent_q, sent_d;

   logic            owner_locked;
   logic [PW-1:0]   owner_idx;
   logic [PW-1:0]   rr_idx;
   logic            rr_found;
   logic [PW-1:0]   cand;
   logic [PW-1:0]   sel;
   logic            accept;

   // grant_q is one-hot, so the owner's lock is simply any lock bit under the grant
   assign owner_locked = |(grant_q & bus.req_lock);

   always_comb begin
      owner_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_q[i]) owner_idx = PW'(i);
      end
   end

   always_comb begin
      rr_idx   = '0;
      rr_found = 1'b0;
      cand     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = PW'((32'(ptr_q) + k) % NREQ);
         if (!rr_found && bus.req_valid[cand]) begin
            rr_idx   = cand;
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      ready_d = '0;
      wr_d    = 1'b0;
      data_d  = data_q;
      sent_d  = sent_q;
      sel     = '0;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            if (owner_locked) begin
               // locked owner is the only eligible requester; others stall
               if (|(grant_q & bus.req_valid)) begin
                  sel    = owner_idx;
                  accept = 1'b1;
               end
            end else begin
               grant_d = '0;
               if (rr_found) begin
                  sel    = rr_idx;
                  accept = 1'b1;
               end
            end
            if (accept) begin
               data_d  = bus.req_data[8*sel +: 8];
               ready_d = NREQ'(1) << sel;
               grant_d = NREQ'(1) << sel;
               ptr_d   = sel;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!bus.uart_busy) begin
               wr_d    = 1'b1;
               state_d = STROBE;
            end
         end
         STROBE: begin
            sent_d  = sent_q + 16'd1;
            state_d = GUARD;
         end
         GUARD: begin
            if (!owner_locked) grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NREQ - 1);
         grant_q <= '0;
         ready_q <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         ready_q <= ready_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         sent_q  <= sent_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.grant      = grant_q;
   assign bus.uart_wr    = wr_q;
   assign bus.uart_data  = data_q;
   assign bus.bytes_sent = sent_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a per-byte arbitration model.
module tb_uart_tx_arbiter;
   localparam int unsigned NREQ = 2;
   localparam int unsigned NMSG = 16;

   logic clk = 1'b0;
   logic rst;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();
   uart_tx_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .reset(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_ready(input logic [NREQ-1:0] exp, input string tag);
      int unsigned n = 0;
      step();
      while (bus.req_ready == '0 && n < 200) begin
         step();
         n++;
      end
      chk(tag, 32'(bus.req_ready), 32'(exp));
   endtask

   task automatic wait_wr(input logic [7:0] exp, input string tag);
      int unsigned n = 0;
      step();
      while (!bus.uart_wr && n < 200) begin
         step();
         n++;
      end
      chk({tag, "_wr"}, 32'(bus.uart_wr), 32'd1);
      chk({tag, "_data"}, 32'(bus.uart_data), 32'(exp));
   endtask

   task automatic idle_inputs();
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_lock  = '0;
      bus.uart_busy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
   endtask

   // reference model state for the randomized phase
   logic [7:0]      msg  [NREQ][NMSG];
   logic            cont [NREQ][NMSG];
   int unsigned     pos  [NREQ];
   int unsigned     gap  [NREQ];
   logic [7:0]      exp_q [$];
   logic [7:0]      exp2 [4];
   int unsigned     last, w, nsent, got, rdy_cnt;
   logic [15:0]     model_cnt;
   logic [NREQ-1:0] oh, prev_rdy;
   bit              done;

   initial begin
      rst = 1'b1;
      idle_inputs();

      // test 1: reset values and a single byte
      step();
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_wr", 32'(bus.uart_wr), 32'd0);
      chk("rst_data", 32'(bus.uart_data), 32'd0);
      chk("rst_sent", 32'(bus.bytes_sent), 32'd0);
      step();
      rst = 1'b0;
      step();
      bus.req_valid = 2'b01;
      bus.req_data[7:0] = 8'h61;
      step();
      chk("t1_ready", 32'(bus.req_ready), 32'h1);
      chk("t1_grant", 32'(bus.grant), 32'h1);
      chk("t1_data_acc", 32'(bus.uart_data), 32'h61);
      chk("t1_wr_early", 32'(bus.uart_wr), 32'd0);
      bus.req_valid = '0;
      step();
      chk("t1_wr", 32'(bus.uart_wr), 32'd1);
      chk("t1_ready_drop", 32'(bus.req_ready), 32'd0);
      chk("t1_data", 32'(bus.uart_data), 32'h61);
      step();
      chk("t1_wr_one", 32'(bus.uart_wr), 32'd0);
      chk("t1_sent", 32'(bus.bytes_sent), 32'd1);
      step();
      chk("t1_grant_rel", 32'(bus.grant), 32'd0);

      // test 2: contention alternates 0,1,0,1 from reset
      do_reset();
      exp2 = '{8'h41, 8'h42, 8'h41, 8'h42};
      bus.req_data  = {8'h42, 8'h41};
      bus.req_valid = 2'b11;
      got = 0;
      rdy_cnt = 0;
      prev_rdy = '0;
      for (int c = 0; c < 100 && got < 4; c++) begin
         step();
         if (bus.req_ready != '0) begin
            chk("t2_ready_1cyc", 32'(bus.req_ready & prev_rdy), 32'd0);
            chk("t2_ready_who", 32'(bus.req_ready), (rdy_cnt % 2 == 0) ? 32'h1 : 32'h2);
            rdy_cnt++;
            if (rdy_cnt == 4) bus.req_valid = '0;
         end
         prev_rdy = bus.req_ready;
         if (bus.uart_wr) begin
            chk("t2_byte", 32'(bus.uart_data), 32'(exp2[got]));
            got++;
         end
      end
      chk("t2_count", got, 32'd4);
      repeat (4) step();

      // test 3: requester 1 locks for three bytes while requester 0 waits
      bus.req_data[15:8] = 8'h10;
      bus.req_lock  = 2'b10;
      bus.req_valid = 2'b10;
      wait_ready(2'b10, "t3_ready0");
      bus.req_data = {8'h11, 8'h20};
      bus.req_valid = 2'b11;
      wait_wr(8'h10, "t3_b0");
      chk("t3_grant0", 32'(bus.grant), 32'h2);
      wait_ready(2'b10, "t3_ready1");
      bus.req_data[15:8] = 8'h12;
      wait_wr(8'h11, "t3_b1");
      wait_ready(2'b10, "t3_ready2");
      bus.req_valid[1] = 1'b0;
      wait_wr(8'h12, "t3_b2");
      for (int c = 0; c < 10; c++) begin
         step();
         chk("t3_stall", 32'({bus.grant, bus.req_ready, bus.uart_wr}), 32'b10_00_0);
      end
      bus.req_lock = '0;
      step();
      chk("t3_release_ready", 32'(bus.req_ready), 32'h1);
      chk("t3_release_grant", 32'(bus.grant), 32'h1);
      bus.req_valid = '0;
      wait_wr(8'h20, "t3_b3");

      // test 4: busy stall
      step();
      bus.req_data[7:0] = 8'h5a;
      bus.req_valid = 2'b01;
      wait_ready(2'b01, "t4_ready");
      bus.req_valid = '0;
      bus.uart_busy = 1'b1;
      for (int c = 0; c < 50; c++) begin
         step();
         chk("t4_stall", 32'({bus.req_ready, bus.uart_wr}), 32'd0);
      end
      bus.uart_busy = 1'b0;
      step();
      chk("t4_wr", 32'(bus.uart_wr), 32'd1);
      chk("t4_data", 32'(bus.uart_data), 32'h5a);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("t4_after", 32'({bus.req_ready, bus.uart_wr}), 32'd0);
      end

      // test 5: reset while waiting on busy
      bus.req_data[7:0] = 8'h77;
      bus.req_valid = 2'b01;
      wait_ready(2'b01, "t5_ready");
      bus.req_valid = '0;
      bus.uart_busy = 1'b1;
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      chk("t5_ready", 32'(bus.req_ready), 32'd0);
      chk("t5_grant", 32'(bus.grant), 32'd0);
      chk("t5_wr", 32'(bus.uart_wr), 32'd0);
      chk("t5_data", 32'(bus.uart_data), 32'd0);
      chk("t5_sent", 32'(bus.bytes_sent), 32'd0);
      bus.uart_busy = 1'b0;
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("t5_quiet", 32'({bus.bytes_sent, bus.uart_wr}), 32'd0);
      end
      bus.req_data[7:0] = 8'h61;
      bus.req_valid = 2'b01;
      step();
      chk("t5_re_ready", 32'(bus.req_ready), 32'h1);
      bus.req_valid = '0;
      step();
      chk("t5_re_wr", 32'(bus.uart_wr), 32'd1);
      chk("t5_re_data", 32'(bus.uart_data), 32'h61);
      step();
      chk("t5_re_sent", 32'(bus.bytes_sent), 32'd1);
      repeat (3) step();

      // test 6: counter wraps after preloading near the top
      force dut.sent_q = 16'hfffe;
      #1 release dut.sent_q;
      for (int b = 0; b < 3; b++) begin
         bus.req_data[7:0] = 8'(8'hc0 + b);
         bus.req_valid = 2'b01;
         wait_ready(2'b01, "t6_ready");
         bus.req_valid = '0;
         wait_wr(8'(8'hc0 + b), "t6_byte");
         step();
         chk("t6_sent", 32'(bus.bytes_sent), 32'(16'(16'hffff + b)));
      end

      // randomized phase: per-byte arbitration model with locks, gaps and busy
      idle_inputs();
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         for (int j = 0; j < NMSG; j++) begin
            msg[i][j]  = 8'($urandom);
            cont[i][j] = (j != NMSG - 1) && ($urandom_range(0, 2) == 0);
         end
         pos[i] = 0;
         gap[i] = $urandom_range(0, 3);
      end
      exp_q.delete();
      last = NREQ - 1;
      model_cnt = '0;
      nsent = 0;
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         step();
         chk("rnd_sent", 32'(bus.bytes_sent), 32'(model_cnt));
         if (bus.uart_wr) begin
            if (exp_q.size() == 0) chk("rnd_wr_pending", 32'(exp_q.size()), 32'd1);
            else chk("rnd_wr_data", 32'(bus.uart_data), 32'(exp_q.pop_front()));
            model_cnt++;
            nsent++;
         end
         if (bus.req_ready != '0) begin
            if (bus.req_lock[last]) w = last;
            else begin
               w = last;
               for (int k = 1; k <= NREQ; k++) begin
                  if (bus.req_valid[(last + k) % NREQ]) begin
                     w = (last + k) % NREQ;
                     break;
                  end
               end
            end
            oh = '0;
            oh[w] = 1'b1;
            chk("rnd_ready", 32'(bus.req_ready), 32'(oh));
            chk("rnd_grant", 32'(bus.grant), 32'(oh));
            chk("rnd_accept_data", 32'(bus.uart_data), 32'(msg[w][pos[w]]));
            exp_q.push_back(msg[w][pos[w]]);
            bus.req_lock[w]  = cont[w][pos[w]];
            bus.req_valid[w] = 1'b0;
            pos[w]++;
            gap[w] = $urandom_range(0, 3);
            last = w;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] && pos[i] < NMSG) begin
               if (gap[i] == 0) begin
                  bus.req_valid[i] = 1'b1;
                  bus.req_data[8*i +: 8] = msg[i][pos[i]];
               end else gap[i]--;
            end
         end
         bus.uart_busy = ($urandom_range(0, 3) == 0);
         done = (nsent == NREQ * NMSG);
      end
      chk("rnd_all_sent", nsent, NREQ * NMSG);
      chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
